// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: FSM state encoding and
// the helper that turns nanosecond timing parameters into clock cycles.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    PRESSED     = 3'd2,
    LONG_HELD   = 3'd3,
    DEB_RELEASE = 3'd4
  } btn_state_t;

  function automatic int ns_to_cycles(input int ns, input int clk_ns);
    return ns / clk_ns;
  endfunction

endpackage

// File: rtl/button_press_ctrl_press_timer.sv
// Loadable down-counter used for the debounce, long-press and repeat timing.
// A load puts MAX_COUNT-1 into the counter; it then counts down while enabled
// and parks at zero, which is what "done" reports.
module press_timer #(
  parameter int MAX_COUNT     = 2,
  parameter int CLK_PERIOD_ns = 20
) (
  input  logic clk,
  input  logic reset_sync,
  input  logic load,
  input  logic enable,
  output logic done
);

  localparam int CNT_W = $clog2(MAX_COUNT + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MAX_COUNT - 1);

  logic [CNT_W-1:0] count;

  if (MAX_COUNT < 2) begin : g_bad_count
    $error("press_timer: MAX_COUNT must be at least 2");
  end

  if (CLK_PERIOD_ns <= 0) begin : g_bad_clk
    $error("press_timer: CLK_PERIOD_ns must be positive");
  end

  // Reload on reset or load, otherwise count down and hold at zero
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      count <= LOAD_VAL;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/button_press_ctrl.sv
// Single push-button front end: synchronises the raw pin, debounces press and
// release, and classifies presses into short / long / auto-repeat events that
// are delivered as one-cycle registered pulses.
module button_press_ctrl
  import btn_pkg::*;
#(
  parameter int CLK_PERIOD_ns  = 20,
  parameter int DEBOUNCE_ns    = 10_000_000,
  parameter int LONG_PRESS_ns  = 1_000_000_000,
  parameter int REPEAT_ns      = 200_000_000,
  parameter bit REPEAT_EN      = 1'b1,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset_sync,
  input  logic btn_in,
  input  logic enable,
  output logic btn_held,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  localparam int DEB_CYC  = ns_to_cycles(DEBOUNCE_ns, CLK_PERIOD_ns);
  localparam int LONG_CYC = ns_to_cycles(LONG_PRESS_ns, CLK_PERIOD_ns);
  localparam int REP_CYC  = ns_to_cycles(REPEAT_ns, CLK_PERIOD_ns);
  localparam logic RELEASED_LVL = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

  if (((DEBOUNCE_ns % CLK_PERIOD_ns) != 0) || (DEB_CYC < 2)) begin : g_bad_deb
    $error("button_press_ctrl: DEBOUNCE_ns must be a multiple of CLK_PERIOD_ns giving >= 2 cycles");
  end
  if (((LONG_PRESS_ns % CLK_PERIOD_ns) != 0) || (LONG_CYC < 2)) begin : g_bad_long
    $error("button_press_ctrl: LONG_PRESS_ns must be a multiple of CLK_PERIOD_ns giving >= 2 cycles");
  end
  if (((REPEAT_ns % CLK_PERIOD_ns) != 0) || (REP_CYC < 2)) begin : g_bad_rep
    $error("button_press_ctrl: REPEAT_ns must be a multiple of CLK_PERIOD_ns giving >= 2 cycles");
  end

  logic       sync1, sync2, btn_s;
  btn_state_t state, state_n;
  logic       was_long, was_long_n;
  logic       deb_load, long_load, rep_load;
  logic       deb_done, long_done, rep_done;
  logic       short_n, long_n, rep_n;

  // Two-flop synchroniser; parked at the released level while reset or disabled
  always_ff @(posedge clk) begin
    if (reset_sync || !enable) begin
      sync1 <= RELEASED_LVL;
      sync2 <= RELEASED_LVL;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign btn_s = BTN_ACTIVE_LOW ? ~sync2 : sync2;

  press_timer #(.MAX_COUNT(DEB_CYC), .CLK_PERIOD_ns(CLK_PERIOD_ns)) u_deb_timer (
    .clk(clk), .reset_sync(reset_sync), .load(deb_load), .enable(enable), .done(deb_done)
  );

  press_timer #(.MAX_COUNT(LONG_CYC), .CLK_PERIOD_ns(CLK_PERIOD_ns)) u_long_timer (
    .clk(clk), .reset_sync(reset_sync), .load(long_load), .enable(enable), .done(long_done)
  );

  press_timer #(.MAX_COUNT(REP_CYC), .CLK_PERIOD_ns(CLK_PERIOD_ns)) u_rep_timer (
    .clk(clk), .reset_sync(reset_sync), .load(rep_load), .enable(enable), .done(rep_done)
  );

  // Next-state, timer loads and event pulses; release bounce never reloads long/repeat timing
  always_comb begin
    state_n    = state;
    was_long_n = was_long;
    deb_load   = 1'b0;
    long_load  = 1'b0;
    rep_load   = 1'b0;
    short_n    = 1'b0;
    long_n     = 1'b0;
    rep_n      = 1'b0;
    if (!enable) begin
      state_n    = IDLE;
      was_long_n = 1'b0;
      deb_load   = 1'b1;
      long_load  = 1'b1;
      rep_load   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (btn_s) begin
            state_n  = DEB_PRESS;
            deb_load = 1'b1;
          end
        end
        DEB_PRESS: begin
          if (!btn_s) begin
            state_n = IDLE;
          end else if (deb_done) begin
            state_n   = PRESSED;
            long_load = 1'b1;
          end
        end
        PRESSED: begin
          if (long_done) begin
            state_n  = LONG_HELD;
            long_n   = 1'b1;
            rep_load = 1'b1;
          end else if (!btn_s) begin
            state_n    = DEB_RELEASE;
            was_long_n = 1'b0;
            deb_load   = 1'b1;
          end
        end
        LONG_HELD: begin
          if (!btn_s) begin
            state_n    = DEB_RELEASE;
            was_long_n = 1'b1;
            deb_load   = 1'b1;
          end else if (rep_done) begin
            rep_load = 1'b1;
            rep_n    = REPEAT_EN;
          end
        end
        DEB_RELEASE: begin
          if (btn_s) begin
            state_n = was_long ? LONG_HELD : PRESSED;
          end else if (deb_done) begin
            state_n = IDLE;
            short_n = ~was_long;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State register and registered outputs derived from the upcoming state
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state        <= IDLE;
      was_long     <= 1'b0;
      btn_held     <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      was_long     <= was_long_n;
      btn_held     <= (state_n == PRESSED) || (state_n == LONG_HELD) || (state_n == DEB_RELEASE);
      short_press  <= short_n;
      long_press   <= long_n;
      repeat_pulse <= rep_n;
      busy         <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_button_press_ctrl.sv
// Bench for button_press_ctrl: directed press scenarios with latency checks,
// followed by random button activity compared cycle by cycle with a
// behavioural model that tracks elapsed time in each press phase.
module tb_button_press_ctrl;

  localparam int DEB = 5;
  localparam int LNG = 20;
  localparam int REP = 10;

  logic clk = 1'b0;
  logic reset_sync, btn_in, enable;
  logic btn_held, short_press, long_press, repeat_pulse, busy;

  button_press_ctrl #(
    .CLK_PERIOD_ns(20), .DEBOUNCE_ns(100), .LONG_PRESS_ns(400), .REPEAT_ns(200),
    .REPEAT_EN(1'b1), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_sync(reset_sync), .btn_in(btn_in), .enable(enable),
    .btn_held(btn_held), .short_press(short_press), .long_press(long_press),
    .repeat_pulse(repeat_pulse), .busy(busy)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef enum {M_IDLE, M_QUALIFY, M_HELD, M_LONG, M_RELEASING} mphase_t;
  mphase_t mph = M_IDLE;
  bit m_p1, m_p2, m_was_long;
  int m_t_deb, m_t_long, m_t_rep;
  bit e_held, e_short, e_long, e_rep, e_busy;

  int held_rise_cyc, held_rise_cnt, held_fall_cnt;
  int long_cyc, long_cnt, short_cyc, short_cnt, rep_cnt;
  int rep_q[$];
  bit busy_seen;
  logic prev_held = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelStep(input bit rst, input bit en, input bit b);
    bit s;
    e_short = 1'b0;
    e_long  = 1'b0;
    e_rep   = 1'b0;
    if (rst || !en) begin
      mph = M_IDLE; m_p1 = 1'b0; m_p2 = 1'b0; m_was_long = 1'b0;
      m_t_deb = 0; m_t_long = 0; m_t_rep = 0;
    end else begin
      s = m_p2;
      m_p2 = m_p1;
      m_p1 = !b;
      m_t_deb++; m_t_long++; m_t_rep++;
      case (mph)
        M_IDLE: if (s) begin mph = M_QUALIFY; m_t_deb = 0; end
        M_QUALIFY: begin
          if (!s) mph = M_IDLE;
          else if (m_t_deb >= DEB) begin mph = M_HELD; m_t_long = 0; end
        end
        M_HELD: begin
          if (m_t_long >= LNG) begin mph = M_LONG; e_long = 1'b1; m_t_rep = 0; end
          else if (!s) begin mph = M_RELEASING; m_was_long = 1'b0; m_t_deb = 0; end
        end
        M_LONG: begin
          if (!s) begin mph = M_RELEASING; m_was_long = 1'b1; m_t_deb = 0; end
          else if (m_t_rep >= REP) begin e_rep = 1'b1; m_t_rep = 0; end
        end
        M_RELEASING: begin
          if (s) mph = m_was_long ? M_LONG : M_HELD;
          else if (m_t_deb >= DEB) begin mph = M_IDLE; e_short = !m_was_long; end
        end
        default: mph = M_IDLE;
      endcase
    end
    e_held = (mph == M_HELD) || (mph == M_LONG) || (mph == M_RELEASING);
    e_busy = (mph != M_IDLE);
  endtask

  task automatic clearLog();
    held_rise_cyc = -1000; held_rise_cnt = 0; held_fall_cnt = 0;
    long_cyc = -1000; long_cnt = 0; short_cyc = -1000; short_cnt = 0;
    rep_cnt = 0; rep_q.delete(); busy_seen = 1'b0;
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic b);
    reset_sync = rst;
    enable     = en;
    btn_in     = b;
    @(posedge clk);
    cyc++;
    modelStep(rst, en, b);
    @(negedge clk);
    checkOutput("btn_held", btn_held, e_held);
    checkOutput("short_press", short_press, e_short);
    checkOutput("long_press", long_press, e_long);
    checkOutput("repeat_pulse", repeat_pulse, e_rep);
    checkOutput("busy", busy, e_busy);
    checkOutput("one_pulse_max", ($countones({short_press, long_press, repeat_pulse}) <= 1), 1);
    if (btn_held === 1'b1 && prev_held !== 1'b1) begin held_rise_cyc = cyc; held_rise_cnt++; end
    if (btn_held !== 1'b1 && prev_held === 1'b1) held_fall_cnt++;
    prev_held = btn_held;
    if (short_press === 1'b1) begin short_cyc = cyc; short_cnt++; end
    if (long_press === 1'b1) begin long_cyc = cyc; long_cnt++; end
    if (repeat_pulse === 1'b1) begin rep_q.push_back(cyc); rep_cnt++; end
    if (busy === 1'b1) busy_seen = 1'b1;
  endtask

  task automatic holdFor(input logic b, input int n);
    repeat (n) applyStimulus(1'b0, 1'b1, b);
  endtask

  initial begin
    int press_cyc, rel_cyc, rst_cyc, en_cyc, dur, roll;
    logic lvl;

    $display("[TB] reset");
    clearLog();
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1);
    holdFor(1'b1, 3);

    $display("[TB] short press");
    clearLog();
    press_cyc = cyc;
    holdFor(1'b0, 15);
    rel_cyc = cyc;
    holdFor(1'b1, 15);
    checkOutput("t1_held_latency", held_rise_cyc - press_cyc, DEB + 3);
    checkOutput("t1_short_count", short_cnt, 1);
    checkOutput("t1_short_latency", short_cyc - rel_cyc, DEB + 3);
    checkOutput("t1_long_count", long_cnt, 0);

    $display("[TB] glitch");
    clearLog();
    holdFor(1'b0, 3);
    holdFor(1'b1, 12);
    checkOutput("t2_busy_seen", busy_seen, 1);
    checkOutput("t2_busy_end", busy, 0);
    checkOutput("t2_held_rises", held_rise_cnt, 0);
    checkOutput("t2_events", short_cnt + long_cnt + rep_cnt, 0);

    $display("[TB] long press with repeat");
    clearLog();
    press_cyc = cyc;
    holdFor(1'b0, 60);
    holdFor(1'b1, 15);
    checkOutput("t3_held_latency", held_rise_cyc - press_cyc, DEB + 3);
    checkOutput("t3_long_latency", long_cyc - held_rise_cyc, LNG);
    checkOutput("t3_long_count", long_cnt, 1);
    checkOutput("t3_rep_count", rep_cnt, 3);
    if (rep_q.size() >= 2) begin
      checkOutput("t3_rep_first", rep_q[0] - long_cyc, REP);
      checkOutput("t3_rep_period", rep_q[1] - rep_q[0], REP);
    end
    checkOutput("t3_short_count", short_cnt, 0);

    $display("[TB] release bounce");
    clearLog();
    holdFor(1'b0, 12);
    holdFor(1'b1, 2);
    holdFor(1'b0, 4);
    holdFor(1'b1, 15);
    checkOutput("t4_held_falls", held_fall_cnt, 1);
    checkOutput("t4_short_count", short_cnt, 1);
    checkOutput("t4_long_count", long_cnt, 0);

    $display("[TB] reset during hold");
    clearLog();
    holdFor(1'b0, 14);
    applyStimulus(1'b1, 1'b1, 1'b0);
    rst_cyc = cyc;
    checkOutput("t5_held_after_reset", btn_held, 0);
    checkOutput("t5_busy_after_reset", busy, 0);
    holdFor(1'b0, 45);
    checkOutput("t5_redebounce", held_rise_cyc - rst_cyc, DEB + 3);
    checkOutput("t5_long_latency", long_cyc - held_rise_cyc, LNG);
    checkOutput("t5_long_count", long_cnt, 1);
    holdFor(1'b1, 15);

    $display("[TB] enable drop in long hold");
    clearLog();
    holdFor(1'b0, 35);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    en_cyc = cyc;
    checkOutput("t6_held_disabled", btn_held, 0);
    checkOutput("t6_busy_disabled", busy, 0);
    holdFor(1'b0, 40);
    checkOutput("t6_redebounce", held_rise_cyc - en_cyc, DEB + 3);
    checkOutput("t6_long_latency", long_cyc - held_rise_cyc, LNG);
    checkOutput("t6_long_count", long_cnt, 2);
    holdFor(1'b1, 15);

    $display("[TB] random activity");
    lvl = 1'b1;
    for (int k = 0; k < 150; k++) begin
      roll = $urandom_range(0, 19);
      if (roll == 0) begin
        applyStimulus(1'b1, 1'b1, lvl);
      end else if (roll == 1) begin
        repeat ($urandom_range(1, 3)) applyStimulus(1'b0, 1'b0, lvl);
      end else begin
        dur = $urandom_range(1, 35);
        lvl = 1'($urandom_range(0, 1));
        holdFor(lvl, dur);
      end
    end
    holdFor(1'b1, 20);
    checkOutput("end_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
